frame_write_scheduler: RTL and testbench

Owns the single write port of the inactive frame buffer in the `clk_system` domain. It sequences each frame in three steps: clear the whole buffer to a background colour, then stream rasterised pixels from the pipeline, then hold `frame_done` until the display side acknowledges the swap. It sits between the pixel pipeline and the frame-buffer write mux, and replaces ad-hoc write logic with one explicit per-frame schedule.

---
 rtl/frame_write_scheduler.sv | 129 ++++++++++++
 tb/tb_frame_write_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_scheduler.sv
// Per-frame write scheduler: clear sweep, then pixel stream, then hold frame_done until acked.
// Writes are registered one cycle after issue; pix_ready is high only in DRAW, one pixel per cycle.
module frame_write_scheduler #(
  parameter int                    BUFFER_WIDTH  = 160,
  parameter int                    BUFFER_HEIGHT = 120,
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    ADDR_WIDTH    = 15,
  parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR   = '0
) (
  input  logic                  clk_system,
  input  logic                  rstn_system,
  input  logic                  draw_start,
  input  logic                  draw_ack,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [7:0]            pix_x,
  input  logic [7:0]            pix_y,
  input  logic [DATA_WIDTH-1:0] pix_color,
  input  logic                  pix_last,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  frame_done,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
);

  localparam int PIXELS = BUFFER_WIDTH * BUFFER_HEIGHT;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        clr_cnt_q;
  logic                    write_en_q;
  logic [ADDR_WIDTH-1:0]   write_addr_q;
  logic [DATA_WIDTH-1:0]   write_data_q;
  logic                    frame_done_q;
  logic [15:0]             frame_count_q;
  logic [15:0]             drop_count_q;

  logic                    pix_accept;
  logic                    pix_in_bounds;
  logic [ADDR_WIDTH-1:0]   pix_addr_d;

  assign pix_ready     = (state_q == S_DRAW);
  assign busy          = (state_q == S_CLEAR) || (state_q == S_DRAW);
  assign pix_accept    = pix_valid & pix_ready;
  assign pix_in_bounds = (32'(pix_x) < BUFFER_WIDTH) && (32'(pix_y) < BUFFER_HEIGHT);
  assign pix_addr_d    = ADDR_WIDTH'(pix_y) * ADDR_WIDTH'(BUFFER_WIDTH) + ADDR_WIDTH'(pix_x);

  // Address 0 is written on the edge that sees draw_start, so the counter starts at 1.
  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      write_en_q    <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      write_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (draw_start) begin
            state_q      <= S_CLEAR;
            write_en_q   <= 1'b1;
            write_addr_q <= '0;
            write_data_q <= CLEAR_COLOR;
            clr_cnt_q    <= CNT_W'(1);
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == CNT_W'(PIXELS)) begin
            state_q   <= S_DRAW;
            clr_cnt_q <= '0;
          end else begin
            write_en_q   <= 1'b1;
            write_addr_q <= clr_cnt_q[ADDR_WIDTH-1:0];
            write_data_q <= CLEAR_COLOR;
            clr_cnt_q    <= clr_cnt_q + CNT_W'(1);
          end
        end
        S_DRAW: begin
          if (pix_accept) begin
            if (pix_in_bounds) begin
              write_en_q   <= 1'b1;
              write_addr_q <= pix_addr_d;
              write_data_q <= pix_color;
            end else if (drop_count_q != 16'hFFFF) begin
              drop_count_q <= drop_count_q + 16'd1;
            end
            if (pix_last) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (draw_ack) begin
            frame_done_q  <= 1'b0;
            frame_count_q <= frame_count_q + 16'd1;
            if (draw_start) begin
              state_q      <= S_CLEAR;
              write_en_q   <= 1'b1;
              write_addr_q <= '0;
              write_data_q <= CLEAR_COLOR;
              clr_cnt_q    <= CNT_W'(1);
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign write_en    = write_en_q;
  assign write_addr  = write_addr_q;
  assign write_data  = write_data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed + randomized bench for frame_write_scheduler against a queue-based reference model.
module tb_frame_write_scheduler;

  localparam int W   = 160;
  localparam int H   = 120;
  localparam int PIX = W * H;

  logic        clk_system  = 1'b0;
  logic        rstn_system = 1'b0;
  logic        draw_start  = 1'b0;
  logic        draw_ack    = 1'b0;
  logic        pix_valid   = 1'b0;
  logic        pix_last    = 1'b0;
  logic [7:0]  pix_x       = '0;
  logic [7:0]  pix_y       = '0;
  logic [11:0] pix_color   = '0;
  logic        pix_ready;
  logic        write_en;
  logic [14:0] write_addr;
  logic [11:0] write_data;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  frame_write_scheduler dut (
    .clk_system (clk_system),
    .rstn_system(rstn_system),
    .draw_start (draw_start),
    .draw_ack   (draw_ack),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .pix_last   (pix_last),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_count(frame_count),
    .drop_count (drop_count)
  );

  always #5 clk_system = ~clk_system;

  int cyc = 0;
  always @(posedge clk_system) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];

  // Every observed write, with the cycle it was visible on.
  always @(negedge clk_system)
    if (write_en === 1'b1) obs_q.push_back('{int'(write_addr), int'(write_data), cyc});

  int n_assert = 0;
  int n_fail   = 0;
  int drop_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_system);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(write_en),    0);
    chk({tag, "_addr"},  32'(write_addr),  0);
    chk({tag, "_data"},  32'(write_data),  0);
    chk({tag, "_done"},  32'(frame_done),  0);
    chk({tag, "_busy"},  32'(busy),        0);
    chk({tag, "_rdy"},   32'(pix_ready),   0);
    chk({tag, "_fcnt"},  32'(frame_count), 0);
    chk({tag, "_dcnt"},  32'(drop_count),  0);
  endtask

  // Start a frame from IDLE and verify the whole clear sweep; leaves the DUT in DRAW.
  task automatic run_clear(input string tag);
    int n;
    int bad;
    int c0;
    obs_q.delete();
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    c0 = cyc;
    chk({tag, "_first_we"},   32'(write_en),   1);
    chk({tag, "_first_addr"}, 32'(write_addr), 0);
    chk({tag, "_busy"},       32'(busy),       1);
    n = 0;
    while (pix_ready !== 1'b1 && n < PIX + 100) begin
      draw_start = (n == 777);
      tick();
      n++;
    end
    draw_start = 1'b0;
    chk({tag, "_len"},  32'(n),           32'(PIX));
    chk({tag, "_nwr"},  32'(obs_q.size()), 32'(PIX));
    bad = 0;
    foreach (obs_q[i])
      if (obs_q[i].addr != i || obs_q[i].data != 0 || obs_q[i].cyc != c0 + i) bad++;
    chk({tag, "_seq"},  32'(bad),      0);
    chk({tag, "_we_off"}, 32'(write_en), 0);
    obs_q.delete();
  endtask

  task automatic send(input int x, input int y, input int c, input bit last);
    pix_valid = 1'b1;
    pix_x     = 8'(x);
    pix_y     = 8'(y);
    pix_color = 12'(c);
    pix_last  = last;
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    if (x < W && y < H) begin
      chk("px_we",   32'(write_en),   1);
      chk("px_addr", 32'(write_addr), 32'(y * W + x));
      chk("px_data", 32'(write_data), 32'(c));
    end else begin
      drop_exp++;
      chk("px_drop_we", 32'(write_en), 0);
    end
  endtask

  initial begin
    int i;
    int n;
    int bad;
    int rdy_bad;
    int x;
    int y;
    int c;
    bit v;

    #3;
    chk_all_zero("rst");
    repeat (3) tick();
    rstn_system = 1'b1;
    repeat (3) tick();
    chk("idle_no_wr", 32'(obs_q.size()), 0);

    // Frame 1: directed pixels
    run_clear("clr1");
    send(0, 0, 12'hF00, 1'b0);
    send(159, 119, 12'h0F0, 1'b0);
    send(5, 2, 12'h00F, 1'b1);
    chk("f1_done",  32'(frame_done), 1);
    chk("f1_rdy",   32'(pix_ready),  0);
    chk("f1_busy",  32'(busy),       0);
    tick();
    chk("f1_we_off", 32'(write_en),  0);
    chk("f1_hold",   32'(frame_done), 1);
    draw_ack = 1'b1;
    tick();
    draw_ack = 1'b0;
    chk("f1_ack_done", 32'(frame_done),  0);
    chk("f1_ack_fcnt", 32'(frame_count), 1);
    obs_q.delete();
    repeat (3) tick();
    chk("idle2_no_wr", 32'(obs_q.size()), 0);

    // Frame 2: bounds, then random stream
    run_clear("clr2");
    draw_ack = 1'b1;
    tick();
    draw_ack = 1'b0;
    chk("ack_in_draw_fcnt", 32'(frame_count), 1);
    chk("ack_in_draw_rdy",  32'(pix_ready),   1);
    send(160, 0, 12'h123, 1'b0);
    send(0, 120, 12'h456, 1'b0);
    chk("oob_drop", 32'(drop_count), 2);
    send(7, 3, 12'hABC, 1'b0);

    tick();
    obs_q.delete();
    exp_q.delete();
    i = 0;
    n = 0;
    rdy_bad = 0;
    while (i < 200 && n < 5000) begin
      v          = 1'($urandom_range(0, 1));
      x          = $urandom_range(0, 169);
      y          = $urandom_range(0, 129);
      c          = $urandom_range(0, 4095);
      pix_valid  = v;
      pix_x      = 8'(x);
      pix_y      = 8'(y);
      pix_color  = 12'(c);
      pix_last   = (i == 199);
      draw_start = ($urandom_range(0, 7) == 0);
      if (pix_ready !== 1'b1) rdy_bad++;
      tick();
      n++;
      if (v) begin
        if (x < W && y < H) exp_q.push_back('{y * W + x, c, cyc});
        else drop_exp++;
        i++;
      end
    end
    pix_valid  = 1'b0;
    pix_last   = 1'b0;
    draw_start = 1'b0;
    chk("rnd_all_sent", 32'(i), 200);
    chk("rnd_rdy",      32'(rdy_bad), 0);
    chk("rnd_done",     32'(frame_done), 1);
    tick();
    chk("rnd_nwr", 32'(obs_q.size()), 32'(exp_q.size()));
    bad = 0;
    foreach (exp_q[k])
      if (k >= obs_q.size() || obs_q[k].addr != exp_q[k].addr ||
          obs_q[k].data != exp_q[k].data || obs_q[k].cyc != exp_q[k].cyc) bad++;
    chk("rnd_writes", 32'(bad), 0);
    chk("rnd_drop",   32'(drop_count), 32'(drop_exp));
    chk("rnd_fcnt",   32'(frame_count), 1);

    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    chk("done_start_ign_busy", 32'(busy),       0);
    chk("done_start_ign_done", 32'(frame_done), 1);

    // Ack and start together go straight into a new clear
    draw_ack   = 1'b1;
    draw_start = 1'b1;
    tick();
    draw_ack   = 1'b0;
    draw_start = 1'b0;
    chk("ackstart_we",   32'(write_en),    1);
    chk("ackstart_addr", 32'(write_addr),  0);
    chk("ackstart_fcnt", 32'(frame_count), 2);
    chk("ackstart_done", 32'(frame_done),  0);
    chk("ackstart_busy", 32'(busy),        1);

    obs_q.delete();
    n = 0;
    while (obs_q.size() < 5000 && n < 10000) begin
      tick();
      n++;
    end
    chk("mid_clear_reached", 32'(obs_q.size() >= 5000), 1);
    rstn_system = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) tick();
    rstn_system = 1'b1;
    obs_q.delete();
    repeat (50) tick();
    chk("post_rst_no_wr", 32'(obs_q.size()), 0);
    chk("post_rst_busy",  32'(busy),         0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
